// File: rtl/i2c_bus_controller.sv
// i2c_bus_controller
// Bus-level front end of the I2C subordinate. Synchronises SCL/SDA into clk,
// detects START/STOP and SCL edges, frames bits and bytes, matches the 7-bit
// device address and produces the ACK/transmit windows for the downstream
// memory interface.
//
// Ports:
//   clk           system clock (only clock)
//   rst           asynchronous active-high reset
//   scl_in        raw I2C SCL
//   sda_in        raw I2C SDA
//   i2c_state     one-hot bus state: [0]IDLE [1]ADDR [2]ADDR_ACK [3]RX_BYTE
//                 [4]DATA_ACK [5]TX_BYTE [6]MASTER_ACK
//   clock_count   bit index within the byte 0..7, 8 during the ACK slot
//   read_bit      latched R/W=1 of the matched address byte
//   write_bit     latched R/W=0 of the matched address byte
//   sda_en        subordinate owns SDA (pad output enable)
//   received_nack master NACKed the last transmitted byte (level)
//   addr_match    one-clk pulse when the address byte equals DEV_ADDR
//   start_det     one-clk pulse on START / repeated START
//   stop_det      one-clk pulse on STOP
module i2c_bus_controller #(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic [6:0] i2c_state,
  output logic [3:0] clock_count,
  output logic       read_bit,
  output logic       write_bit,
  output logic       sda_en,
  output logic       received_nack,
  output logic       addr_match,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [6:0] {
    ST_IDLE       = 7'b0000001,
    ST_ADDR       = 7'b0000010,
    ST_ADDR_ACK   = 7'b0000100,
    ST_RX_BYTE    = 7'b0001000,
    ST_DATA_ACK   = 7'b0010000,
    ST_TX_BYTE    = 7'b0100000,
    ST_MASTER_ACK = 7'b1000000
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_cond;
  logic                   stop_cond;
  logic [7:0]             shift;
  // Set by an SCL rise, cleared by the following fall. The SCL fall that
  // directly follows a START closes no bit and must not be counted.
  logic                   bit_open;

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_q;
  assign scl_fall   = ~scl_s & scl_q;
  assign start_cond = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_cond  = scl_s & scl_q & ~sda_q & sda_s;
  assign i2c_state  = state;

  // Input synchronisers plus one-cycle delayed copies; reset to the idle-bus
  // level (high) so release never fabricates an edge or START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  // Bus state machine; sda_en is written alongside every state change so it
  // always tracks the registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      clock_count   <= 4'd0;
      read_bit      <= 1'b0;
      write_bit     <= 1'b0;
      sda_en        <= 1'b0;
      received_nack <= 1'b0;
      addr_match    <= 1'b0;
      start_det     <= 1'b0;
      stop_det      <= 1'b0;
      shift         <= 8'd0;
      bit_open      <= 1'b0;
    end else begin
      addr_match <= 1'b0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      if (stop_cond) begin
        state         <= ST_IDLE;
        clock_count   <= 4'd0;
        read_bit      <= 1'b0;
        write_bit     <= 1'b0;
        received_nack <= 1'b0;
        sda_en        <= 1'b0;
        stop_det      <= 1'b1;
        bit_open      <= 1'b0;
      end else if (start_cond) begin
        state         <= ST_ADDR;
        clock_count   <= 4'd0;
        read_bit      <= 1'b0;
        write_bit     <= 1'b0;
        received_nack <= 1'b0;
        sda_en        <= 1'b0;
        start_det     <= 1'b1;
        bit_open      <= 1'b0;
      end else begin
        if (scl_rise) begin
          bit_open <= 1'b1;
        end else if (scl_fall) begin
          bit_open <= 1'b0;
        end
        case (state)
          ST_IDLE: begin
            sda_en <= 1'b0;
          end
          ST_ADDR: begin
            if (scl_rise) begin
              // MSB first: bit index 0 lands in shift[7]
              shift[3'd7 - clock_count[2:0]] <= sda_s;
            end else if (scl_fall && bit_open) begin
              if (clock_count == 4'd7) begin
                if (shift[7:1] == DEV_ADDR) begin
                  state       <= ST_ADDR_ACK;
                  clock_count <= 4'd8;
                  addr_match  <= 1'b1;
                  read_bit    <= shift[0];
                  write_bit   <= ~shift[0];
                  sda_en      <= 1'b1;
                end else begin
                  state       <= ST_IDLE;
                  clock_count <= 4'd0;
                  sda_en      <= 1'b0;
                end
              end else begin
                clock_count <= clock_count + 4'd1;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall && bit_open) begin
              clock_count <= 4'd0;
              state       <= read_bit ? ST_TX_BYTE : ST_RX_BYTE;
              sda_en      <= read_bit;
            end
          end
          ST_RX_BYTE: begin
            if (scl_fall && bit_open) begin
              clock_count <= clock_count + 4'd1;
              if (clock_count == 4'd7) begin
                state  <= ST_DATA_ACK;
                sda_en <= 1'b1;
              end
            end
          end
          ST_DATA_ACK: begin
            if (scl_fall && bit_open) begin
              clock_count <= 4'd0;
              state       <= ST_RX_BYTE;
              sda_en      <= 1'b0;
            end
          end
          ST_TX_BYTE: begin
            if (scl_fall && bit_open) begin
              clock_count <= clock_count + 4'd1;
              if (clock_count == 4'd7) begin
                state  <= ST_MASTER_ACK;
                sda_en <= 1'b0;
              end
            end
          end
          ST_MASTER_ACK: begin
            if (scl_rise && sda_s) begin
              received_nack <= 1'b1;
            end else if (scl_fall && bit_open) begin
              clock_count <= 4'd0;
              if (received_nack) begin
                state  <= ST_IDLE;
                sda_en <= 1'b0;
              end else begin
                state  <= ST_TX_BYTE;
                sda_en <= 1'b1;
              end
            end
          end
          default: begin
            state       <= ST_IDLE;
            clock_count <= 4'd0;
            sda_en      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_controller.sv
module tb_i2c_bus_controller;
  localparam logic [6:0] DEV  = 7'h42;
  localparam int         HOLD = 5;
  localparam logic [6:0] S_IDLE = 7'b0000001, S_ADDR = 7'b0000010,
                         S_AACK = 7'b0000100, S_RX   = 7'b0001000,
                         S_DACK = 7'b0010000, S_TX   = 7'b0100000,
                         S_MACK = 7'b1000000;

  logic clk = 1'b0, rst = 1'b1, scl_in = 1'b1, sda_in = 1'b1;
  logic [6:0] i2c_state;
  logic [3:0] clock_count;
  logic read_bit, write_bit, sda_en, received_nack, addr_match, start_det, stop_det;
  logic [6:0] i2c_state3;
  logic [3:0] clock_count3;
  logic read_bit3, write_bit3, sda_en3, received_nack3, addr_match3, start_det3, stop_det3;

  i2c_bus_controller #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .i2c_state(i2c_state), .clock_count(clock_count), .read_bit(read_bit),
    .write_bit(write_bit), .sda_en(sda_en), .received_nack(received_nack),
    .addr_match(addr_match), .start_det(start_det), .stop_det(stop_det));

  i2c_bus_controller #(.DEV_ADDR(DEV), .SYNC_STAGES(3)) u_dut3 (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .i2c_state(i2c_state3), .clock_count(clock_count3), .read_bit(read_bit3),
    .write_bit(write_bit3), .sda_en(sda_en3), .received_nack(received_nack3),
    .addr_match(addr_match3), .start_det(start_det3), .stop_det(stop_det3));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Snapshot of all outputs: {state, count, rb, wb, sda_en, nack, am, sd, pd}
  logic [17:0] exp_q[$];
  logic [17:0] m_last;
  logic [17:0] mon_prev;

  // Reference model of the bus, one update per bus event
  logic [6:0] m_state;
  logic [3:0] m_cc;
  logic       m_rb, m_wb, m_nack;
  logic [7:0] m_byte;

  function automatic logic [17:0] snap(input logic [6:0] st, input logic [3:0] cc,
      input logic rb, input logic wb, input logic en, input logic nk,
      input logic am, input logic sd, input logic pd);
    return {st, cc, rb, wb, en, nk, am, sd, pd};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Queue the model's output view if it differs from the last queued one
  task automatic push(input logic am, input logic sd, input logic pd);
    logic en;
    logic [17:0] s;
    en = (m_state == S_AACK) || (m_state == S_DACK) || (m_state == S_TX);
    s = snap(m_state, m_cc, m_rb, m_wb, en, m_nack, am, sd, pd);
    if (s != m_last) begin
      exp_q.push_back(s);
      m_last = s;
    end
  endtask

  task automatic model_clear(input logic [6:0] st);
    m_state = st; m_cc = 4'd0; m_rb = 1'b0; m_wb = 1'b0; m_nack = 1'b0; m_byte = 8'd0;
  endtask

  task automatic model_rise(input logic b);
    if (m_state == S_MACK && b) m_nack = 1'b1;
    push(1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_fall(input logic b);
    if (m_state == S_ADDR) begin
      m_byte = {m_byte[6:0], b};
      m_cc = m_cc + 4'd1;
      if (m_cc == 4'd8 && m_byte[7:1] == DEV) begin
        m_state = S_AACK; m_rb = m_byte[0]; m_wb = ~m_byte[0];
        push(1'b1, 1'b0, 1'b0);
      end else if (m_cc == 4'd8) begin
        m_state = S_IDLE; m_cc = 4'd0;
      end
    end else if (m_state == S_AACK) begin
      m_cc = 4'd0; m_state = m_rb ? S_TX : S_RX;
    end else if (m_state == S_RX || m_state == S_TX) begin
      m_cc = m_cc + 4'd1;
      if (m_cc == 4'd8) m_state = (m_state == S_RX) ? S_DACK : S_MACK;
    end else if (m_state == S_DACK) begin
      m_cc = 4'd0; m_state = S_RX;
    end else if (m_state == S_MACK) begin
      m_cc = 4'd0; m_state = m_nack ? S_IDLE : S_TX;
    end
    push(1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    if (scl_in == 1'b0) begin
      sda_in = 1'b1; wait_clks(HOLD);
      scl_in = 1'b1; wait_clks(HOLD);
    end
    model_clear(S_ADDR);
    push(1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b0, 1'b0);
    sda_in = 1'b0; wait_clks(HOLD);
    scl_in = 1'b0; wait_clks(HOLD);
  endtask

  task automatic bus_stop();
    sda_in = 1'b0; wait_clks(HOLD);
    scl_in = 1'b1; wait_clks(HOLD);
    model_clear(S_IDLE);
    push(1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b0);
    sda_in = 1'b1; wait_clks(HOLD);
  endtask

  task automatic bus_bit(input logic b);
    sda_in = b; wait_clks(HOLD);
    model_rise(b);
    scl_in = 1'b1; wait_clks(HOLD);
    model_fall(b);
    scl_in = 1'b0; wait_clks(HOLD);
  endtask

  task automatic bus_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) bus_bit(v[i]);
  endtask

  // Monitor: every change of the DUT's output view is matched against the queue
  always @(negedge clk) begin
    logic [17:0] cur;
    logic [17:0] e;
    cur = snap(i2c_state, clock_count, read_bit, write_bit, sda_en, received_nack,
               addr_match, start_det, stop_det);
    if (cur !== mon_prev) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL snapshot: got %h expected no change", cur);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          fails++;
          $display("FAIL snapshot: got %h expected %h", cur, e);
        end
      end
      mon_prev = cur;
    end
  end

  initial begin
    model_clear(S_IDLE);
    m_last   = snap(S_IDLE, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mon_prev = m_last;
    wait_clks(3);
    check("reset_state", i2c_state, S_IDLE);
    check("reset_count", clock_count, 4'd0);
    check("reset_misc", {read_bit, write_bit, sda_en, received_nack, addr_match,
                         start_det, stop_det}, 7'd0);
    rst = 1'b0;
    wait_clks(4);

    // START latency: 2-stage sync gives 3 clks, 3-stage gives 4
    model_clear(S_ADDR);
    push(1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b0, 1'b0);
    sda_in = 1'b0;
    wait_clks(2);
    check("lat_early", start_det, 1'b0);
    wait_clks(1);
    check("lat_sync2", start_det, 1'b1);
    check("lat_sync3_early", start_det3, 1'b0);
    wait_clks(1);
    check("lat_sync3", start_det3, 1'b1);
    wait_clks(HOLD);
    scl_in = 1'b0; wait_clks(HOLD);

    // Address write
    bus_byte(8'h84);
    check("aw_state", i2c_state, S_AACK);
    check("aw_count", clock_count, 4'd8);
    check("aw_rw", {read_bit, write_bit, sda_en}, 3'b011);
    bus_bit(1'b0);
    check("aw_rx_state", i2c_state, S_RX);
    check("aw_rx_count", clock_count, 4'd0);
    bus_byte(8'($urandom)); bus_bit(1'b0);
    bus_stop();

    // Wrong address
    bus_start();
    bus_byte(8'h86);
    check("wa_idle", i2c_state, S_IDLE);
    bus_bit(1'b0);
    check("wa_sda_en", sda_en, 1'b0);
    bus_byte(8'h84); bus_bit(1'b0);
    check("wa_ignored", i2c_state, S_IDLE);
    bus_stop();

    // Master read, two bytes
    bus_start();
    bus_byte(8'h85); bus_bit(1'b0);
    check("rd_tx", {i2c_state, sda_en}, {S_TX, 1'b1});
    bus_byte(8'($urandom)); bus_bit(1'b0);
    check("rd_tx_again", i2c_state, S_TX);
    bus_byte(8'($urandom)); bus_bit(1'b1);
    check("rd_nack", {i2c_state, received_nack, read_bit}, {S_IDLE, 2'b11});
    bus_stop();
    check("rd_nack_clr", received_nack, 1'b0);

    // Repeated START mid-byte
    bus_start();
    bus_byte(8'h84); bus_bit(1'b0);
    bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1);
    bus_start();
    check("rs_count", {i2c_state, clock_count}, {S_ADDR, 4'd0});
    bus_byte(8'h85); bus_bit(1'b0);
    check("rs_rw", {read_bit, write_bit}, 2'b10);
    bus_byte(8'($urandom)); bus_bit(1'b1);
    bus_stop();

    // Reset in TX_BYTE at clock_count 5
    bus_start();
    bus_byte(8'h85); bus_bit(1'b0);
    for (int i = 0; i < 5; i++) bus_bit(1'b1);
    check("rm_pre", {i2c_state, clock_count}, {S_TX, 4'd5});
    model_clear(S_IDLE);
    push(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("rm_state", i2c_state, S_IDLE);
    check("rm_en_cnt", {sda_en, clock_count}, 5'd0);
    wait_clks(3);
    rst = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 4; i++) begin
      scl_in = 1'b1; wait_clks(HOLD);
      scl_in = 1'b0; wait_clks(HOLD);
    end
    check("rm_ignored", i2c_state, S_IDLE);
    bus_stop();

    // Randomised transactions
    for (int t = 0; t < 25; t++) begin
      logic [7:0] ab;
      int nb;
      int tail;
      bus_start();
      if ($urandom_range(0, 2) != 0) ab = {DEV, 1'($urandom_range(0, 1))};
      else ab = 8'($urandom);
      bus_byte(ab); bus_bit(1'b0);
      nb = $urandom_range(1, 3);
      if (m_state == S_TX) begin
        for (int k = 0; k < nb; k++) begin
          bus_byte(8'($urandom)); bus_bit(k == nb - 1);
        end
      end else begin
        for (int k = 0; k < nb; k++) begin
          bus_byte(8'($urandom)); bus_bit(1'b0);
        end
        tail = $urandom_range(0, 4);
        for (int j = 0; j < tail; j++) bus_bit(1'($urandom_range(0, 1)));
      end
      if (t == 24 || $urandom_range(0, 1) == 1) bus_stop();
    end

    wait_clks(10);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_bus_controller.md
Name: i2c_bus_controller

Overview:
Bus-level front end of the I2C subordinate. It synchronises SCL/SDA into the system clock and detects START, STOP and SCL edges. It frames bits and bytes, matches the 7-bit device address, and generates the ACK/transmit windows. Its outputs (i2c_state, clock_count, read_bit, write_bit, sda_en, received_nack) feed the memory interface directly downstream, which supplies the SDA data/ACK value and memory sequencing.

Parameters:
DEV_ADDR, 7'h42, 7-bit subordinate address this block answers to.
SYNC_STAGES, 2, flop stages on scl_in/sda_in before edge detection (minimum 2).

Ports:
clk  input  1  system clock; the only clock in the block
rst  input  1  reset, asynchronous, active-high
scl_in  input  1  raw I2C SCL
sda_in  input  1  raw I2C SDA
i2c_state  output  7  one-hot bus state (encoding below)
clock_count  output  4  bit index within the current byte, 0..7; 8 during the ACK slot
read_bit  output  1  latched R/W=1 of the matched address byte (master read)
write_bit  output  1  latched R/W=0 of the matched address byte (master write)
sda_en  output  1  subordinate owns SDA (pad output enable)
received_nack  output  1  master NACKed the last transmitted byte
addr_match  output  1  one-clk pulse when the address byte equals DEV_ADDR
start_det  output  1  one-clk pulse on START or repeated START
stop_det  output  1  one-clk pulse on STOP

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: i2c_state=7'b0000001 (IDLE), clock_count=0, and all other outputs 0. Assertion mid-transfer aborts immediately. After release the block waits for a fresh START.
- Sync: scl_s and sda_s are the SYNC_STAGES-deep synchronised inputs; scl_q and sda_q are their one-cycle-delayed copies.
  - scl_rise = scl_s & ~scl_q; scl_fall = ~scl_s & scl_q.
  - START = scl_s & scl_q & sda_q & ~sda_s; STOP = scl_s & scl_q & ~sda_q & sda_s.
  - Detection latency: SYNC_STAGES+1 clks after the pin change.
- Data is sampled on scl_rise. State and clock_count advance on scl_fall. All outputs are registered.
- One-hot encoding: bit0 IDLE, bit1 ADDR, bit2 ADDR_ACK, bit3 RX_BYTE, bit4 DATA_ACK, bit5 TX_BYTE, bit6 MASTER_ACK.
- Priority, evaluated every clk: STOP > START > scl edges.
  - STOP from any state: go to IDLE; clear clock_count, read_bit, write_bit and received_nack; pulse stop_det.
  - START from any state, including mid-byte (repeated START): go to ADDR; clock_count=0; clear read_bit, write_bit and received_nack; pulse start_det.
- IDLE: ignore SCL edges.
- ADDR:
  - On scl_rise, shift[7-clock_count] <= sda_s. On scl_fall, clock_count increments.
  - On the fall that makes clock_count=8, if shift[7:1]==DEV_ADDR: go to ADDR_ACK, pulse addr_match, read_bit=shift[0], write_bit=~shift[0].
  - Otherwise go to IDLE (ignore traffic until the next START).
- ADDR_ACK: sda_en=1 (downstream drives 0). On scl_fall: clock_count=0; go to TX_BYTE if read_bit, else RX_BYTE.
- RX_BYTE: sda_en=0. clock_count increments on each scl_fall. On the fall reaching 8, go to DATA_ACK.
- DATA_ACK: sda_en=1. On scl_fall: clock_count=0, go to RX_BYTE. Byte count is unbounded.
- TX_BYTE:
  - sda_en=1 for the whole byte, asserted in the same registered cycle the state is entered.
  - clock_count increments on each scl_fall. On the fall reaching 8, go to MASTER_ACK with sda_en=0.
- MASTER_ACK:
  - On scl_rise, if sda_s=1 set received_nack=1 (level; held until START, STOP or rst).
  - On scl_fall: if received_nack, go to IDLE and keep read_bit; otherwise clock_count=0 and go to TX_BYTE.
- clock_count never exceeds 8. Wrap 8→0 happens only on leaving an ACK state.
- sda_en is a pure function of the registered state: 1 in ADDR_ACK, DATA_ACK and TX_BYTE; 0 elsewhere.
- SDA glitches while SCL is high inside a byte are treated as START/STOP by definition.

Test Plan:
- Address write: START, byte 0x84 (addr 0x42, W) → addr_match pulse; write_bit=1, read_bit=0; state ADDR_ACK with sda_en=1 and clock_count=8; after the 9th fall, RX_BYTE with clock_count=0.
- Wrong address: START, byte 0x86 (addr 0x43) → no addr_match; IDLE after the 8th fall; sda_en stays 0 through the 9th clock; subsequent bytes are ignored.
- Master read, 2 bytes: START, 0x85 → TX_BYTE with sda_en=1. Master ACK (SDA=0) → TX_BYTE again. Master NACK → received_nack=1, then IDLE. STOP → received_nack=0 and stop_det pulses.
- Repeated START: write 0x84 plus 3 data bits, then START, then 0x85 → start_det pulses; clock_count resets to 0 at the START; read_bit=1, write_bit=0 after the second address.
- Reset mid-TX_BYTE at clock_count=5 → same clk: i2c_state=7'b0000001, sda_en=0, clock_count=0. SCL toggling after release is ignored until START.
- Latency: with SYNC_STAGES=2, a START pin event produces start_det exactly 3 clks later; a 3-stage build produces it 4 clks later.
